// File: rtl/fir_filter.sv
// fir_filter: 64-tap distributed-arithmetic FIR filter.
//
// Each accepted sample is processed bit-serially. For every sample bit
// j (LSB first) and every group k of eight taps, one partial-sum word is
// read from a preloaded table and added to a wide accumulator with weight
// 2^j. The word for the sign bit (j = DW-1) is subtracted. The result is
// shifted right by DW-1 and saturated to DW bits.
//
// State table:
//   IDLE | waiting for a sample strobe; the LUT may be loaded
//   RUN  | 128 table reads plus two cycles to drain the read pipeline
//
// Ports:
//   clk_fast   in   1      the only clock, rising edge
//   resetn     in   1      synchronous reset, active high (1 resets)
//   din        in   DW     signed input sample
//   valid_in   in   1      one-cycle sample strobe
//   CIN        in   LW     signed LUT write data
//   CADDR      in   AW     LUT write address
//   CLOAD      in   1      LUT write enable, takes priority over valid_in
//   dout       out  DW     signed filter output, held between results
//   valid_out  out  1      one-cycle pulse marking a new dout
module fir_filter #(
  parameter int NTAPS = 64,
  parameter int DW    = 16,
  parameter int LW    = 19,
  parameter int AW    = 11
) (
  input  logic                 clk_fast,
  input  logic                 resetn,
  input  logic signed [DW-1:0] din,
  input  logic                 valid_in,
  input  logic signed [LW-1:0] CIN,
  input  logic        [AW-1:0] CADDR,
  input  logic                 CLOAD,
  output logic signed [DW-1:0] dout,
  output logic                 valid_out
);

  localparam int NG    = NTAPS / 8;
  localparam int GW    = $clog2(NG);
  localparam int BW    = $clog2(DW);
  localparam int NREAD = DW * NG;
  localparam int CW    = 8;
  localparam int ACCW  = 40;

  localparam logic [BW-1:0]          MSB_BIT = BW'(DW - 1);
  localparam logic [CW-1:0]          LAST_RD = CW'(NREAD);
  localparam logic [CW-1:0]          DONE_CT = CW'(NREAD + 1);
  localparam logic signed [ACCW-1:0] SAT_HI  = ACCW'((1 << (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_LO  = ~SAT_HI;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic        [CW-1:0]   cnt;
  logic signed [DW-1:0]   x [NTAPS];

  logic signed [LW-1:0]   mem [2**AW];
  logic signed [LW-1:0]   rdata;
  logic        [AW-1:0]   rd_addr;
  logic        [7:0]      abits;
  logic        [GW-1:0]   rd_k;
  logic        [BW-1:0]   rd_bit;

  logic                   rd_vld;
  logic        [BW-1:0]   rd_j;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] term;
  logic signed [ACCW-1:0] shifted;
  logic signed [DW-1:0]   sat;

  // Read order: bit j outer, group k inner, so the low count bits pick
  // the group and the next bits pick the sample bit.
  assign rd_k   = cnt[GW-1:0];
  assign rd_bit = cnt[GW +: BW];

  always_comb begin
    abits = '0;
    for (int b = 0; b < 8; b++) begin
      abits[b] = x[{rd_k, 3'(b)}][rd_bit];
    end
    rd_addr = {rd_k, abits};
  end

  // Table is deliberately not reset; contents survive resetn.
  always_ff @(posedge clk_fast) begin
    if (CLOAD) begin
      mem[CADDR] <= CIN;
    end
    rdata <= mem[rd_addr];
  end

  always_comb begin
    term    = $signed({{(ACCW-LW){rdata[LW-1]}}, rdata}) <<< rd_j;
    shifted = acc >>> (DW - 1);
    if (shifted > SAT_HI) begin
      sat = SAT_HI[DW-1:0];
    end else if (shifted < SAT_LO) begin
      sat = SAT_LO[DW-1:0];
    end else begin
      sat = shifted[DW-1:0];
    end
  end

  // Count c issues read c (c < NREAD) while the word from read c-1,
  // tagged by rd_vld/rd_j, is accumulated. The result is registered at
  // c = NREAD+1, i.e. 130 edges after the capturing edge.
  always_ff @(posedge clk_fast) begin
    if (resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      rd_vld    <= 1'b0;
      rd_j      <= '0;
      dout      <= '0;
      valid_out <= 1'b0;
      for (int t = 0; t < NTAPS; t++) begin
        x[t] <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          rd_vld <= 1'b0;
          if (valid_in && !CLOAD) begin
            for (int t = NTAPS - 1; t > 0; t--) begin
              x[t] <= x[t-1];
            end
            x[0]  <= din;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          rd_vld <= (cnt < LAST_RD);
          rd_j   <= rd_bit;
          if (rd_vld) begin
            acc <= (rd_j == MSB_BIT) ? acc - term : acc + term;
          end
          cnt <= cnt + 1'b1;
          if (cnt == DONE_CT) begin
            dout      <= sat;
            valid_out <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
module tb_fir_filter;

  logic               clk_fast = 1'b0;
  logic               resetn   = 1'b1;
  logic signed [15:0] din      = '0;
  logic               valid_in = 1'b0;
  logic signed [18:0] CIN      = '0;
  logic        [10:0] CADDR    = '0;
  logic               CLOAD    = 1'b0;
  logic signed [15:0] dout;
  logic               valid_out;

  int n_assert = 0;
  int n_fail   = 0;

  int h  [64];
  int xm [64];

  always #5 clk_fast = ~clk_fast;

  fir_filter dut (
    .clk_fast  (clk_fast),
    .resetn    (resetn),
    .din       (din),
    .valid_in  (valid_in),
    .CIN       (CIN),
    .CADDR     (CADDR),
    .CLOAD     (CLOAD),
    .dout      (dout),
    .valid_out (valid_out)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: direct convolution, floor shift, clamp.
  function automatic longint model_out();
    longint full;
    longint q;
    full = 0;
    for (int t = 0; t < 64; t++) full += longint'(h[t]) * longint'(xm[t]);
    q = full >>> 15;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic model_push(input int d);
    for (int t = 63; t > 0; t--) xm[t] = xm[t-1];
    xm[0] = d;
  endtask

  task automatic model_clear();
    for (int t = 0; t < 64; t++) xm[t] = 0;
  endtask

  task automatic set_single(input int tap, input int val);
    for (int t = 0; t < 64; t++) h[t] = 0;
    h[tap] = val;
  endtask

  // Build each partial-sum entry from the coefficient set and write it.
  task automatic load_lut();
    for (int a = 0; a < 2048; a++) begin
      int s;
      s = 0;
      for (int b = 0; b < 8; b++) if (a[b]) s += h[(a >> 8) * 8 + b];
      @(negedge clk_fast);
      CLOAD = 1'b1;
      CADDR = a[10:0];
      CIN   = s[18:0];
    end
    @(negedge clk_fast);
    CLOAD = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_fast);
    resetn = 1'b1;
    @(negedge clk_fast);
    resetn = 1'b0;
    model_clear();
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // Called at a negedge; the strobe is captured at the following posedge.
  task automatic run_sample(input int d, input string tag);
    int     cyc;
    longint exp;
    din      = 16'(d);
    valid_in = 1'b1;
    model_push(d);
    exp = model_out();
    cyc = 0;
    do begin
      @(negedge clk_fast);
      cyc++;
      valid_in = 1'b0;
    end while (!valid_out && cyc < 200);
    check({tag, " latency"}, cyc, 131);
    check({tag, " dout"}, dout, exp);
  endtask

  int                 cyc;
  int                 pulses;
  int                 lat;
  int                 d_a;
  int                 d_b;
  longint             exp_v;
  logic signed [15:0] got;

  initial begin
    model_clear();
    for (int t = 0; t < 64; t++) h[t] = 0;
    repeat (3) @(negedge clk_fast);
    resetn = 1'b0;
    check("reset dout", dout, 0);
    check("reset valid_out", valid_out, 0);

    // all-zero table
    load_lut();
    for (int i = 0; i < 5; i++) run_sample(rand_sample(), "zero_lut");

    // single tap 0
    set_single(0, 16384);
    load_lut();
    do_reset();
    run_sample(1000, "h0 pos");
    run_sample(-1000, "h0 neg");

    // single tap 5: impulse appears five samples later
    set_single(5, 32767);
    load_lut();
    do_reset();
    run_sample(1000, "h5 s0");
    for (int i = 1; i < 7; i++) run_sample(0, "h5 zeros");

    // saturation and most-negative input
    set_single(0, -32768);
    load_lut();
    do_reset();
    run_sample(-32768, "sat hi");
    set_single(0, 32767);
    load_lut();
    do_reset();
    run_sample(-32768, "neg full");

    // random coefficients and samples
    for (int t = 0; t < 64; t++) h[t] = int'($urandom_range(8190)) - 4095;
    load_lut();
    do_reset();
    for (int i = 0; i < 8; i++) run_sample(rand_sample(), "random");

    // second strobe 50 cycles into RUN is dropped
    d_a = rand_sample();
    d_b = rand_sample();
    din = 16'(d_a);
    valid_in = 1'b1;
    model_push(d_a);
    exp_v = model_out();
    cyc = 0; pulses = 0; lat = -1; got = '0;
    while (cyc < 300) begin
      @(negedge clk_fast);
      cyc++;
      if (cyc == 50) begin
        din = 16'(d_b);
        valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      if (valid_out) begin
        pulses++;
        if (lat < 0) begin
          lat = cyc;
          got = dout;
        end
      end
    end
    check("busy pulses", pulses, 1);
    check("busy latency", lat, 131);
    check("busy dout", got, exp_v);
    check("dout held", dout, exp_v);
    for (int i = 0; i < 2; i++) run_sample(rand_sample(), "after busy");

    // strobe coinciding with a table write is ignored
    din = 16'(rand_sample());
    valid_in = 1'b1;
    CLOAD = 1'b1;
    CADDR = '0;
    CIN   = '0;
    @(negedge clk_fast);
    valid_in = 1'b0;
    CLOAD = 1'b0;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_fast);
      if (valid_out) pulses++;
    end
    check("cload priority pulses", pulses, 0);
    for (int i = 0; i < 2; i++) run_sample(rand_sample(), "after cload");

    // reset during RUN aborts; table survives
    set_single(0, 16384);
    load_lut();
    do_reset();
    din = 16'(1234);
    valid_in = 1'b1;
    cyc = 0; pulses = 0;
    while (cyc < 250) begin
      @(negedge clk_fast);
      cyc++;
      valid_in = 1'b0;
      resetn = (cyc == 60);
      if (valid_out) pulses++;
    end
    model_clear();
    check("abort pulses", pulses, 0);
    check("abort dout", dout, 0);
    run_sample(1000, "post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_filter.md
Name: fir_filter

Overview:
- 64-tap FIR filter built on distributed arithmetic (DA), with 16-bit signed samples in and 16-bit signed results out.
- Coefficients are never stored directly. Software preloads a 2048-entry table of precomputed partial sums, organised as 8 groups × 256 entries, through a write port.
- The datapath processes each sample bit-serially on a single fast clock. Samples arrive as single-cycle strobes at a much lower rate.

Parameters:
- NTAPS, 64, number of taps (8 groups of 8).
- DW, 16, sample and output width.
- LW, 19, LUT word width (signed).
- AW, 11, LUT address width.

Ports:
- clk_fast  in  1  the only clock; all logic on its rising edge.
- resetn  in  1  synchronous, active-high reset (resetn=1 resets).
- din  in  16  signed input sample, captured when valid_in=1.
- valid_in  in  1  one-cycle sample strobe.
- CIN  in  19  signed LUT write data.
- CADDR  in  11  LUT write address.
- CLOAD  in  1  LUT write enable.
- dout  out  16  signed filter output.
- valid_out  out  1  one-cycle pulse marking a new dout.

Behaviour:
- Reset (resetn=1 at a rising edge):
  - dout=0, valid_out=0.
  - Delay line cleared to 0; FSM to IDLE; accumulator=0.
  - LUT contents are not cleared.
  - Reset mid-computation aborts it; no valid_out is produced.
- LUT write: when CLOAD=1, mem[CADDR] <= CIN at that edge. Writes are allowed in any state.
- CLOAD priority: while CLOAD=1, valid_in is ignored.
- LUT meaning: entry k*256+a = sum over b=0..7 of a[b] ? h[8k+b] : 0. Tap t multiplies x[n-t]; tap 0 is the newest sample.
- Sample capture: in IDLE, valid_in=1 with CLOAD=0 does both of the following, and the FSM enters RUN:
  - shifts din into x[0]; x[t] <= x[t-1] for t=1..63; x[63] is discarded.
- valid_in in any state other than IDLE is ignored; the sample is dropped and the delay line is unchanged.
- RUN: 128 LUT reads, one per cycle. Order: bit j=0..15 outer, group k=0..7 inner.
  - Address = k*256 + {x[8k+7][j], …, x[8k][j]}.
  - The LUT read is synchronous (1-cycle latency).
  - Each returned word, sign-extended, is added to a ≥40-bit signed accumulator with weight 2^j.
  - For j=15 the word is subtracted instead (two's-complement MSB).
- Result: full = Σ_t h[t]·x[n-t], exact.
- dout = saturate16(full >>> 15): arithmetic shift, floor rounding, clamped to [-32768, 32767].
- Timing:
  - valid_in captured at edge T.
  - dout updated and valid_out=1 for exactly one cycle, registered at edge T+130.
  - FSM returns to IDLE at T+130, so a new valid_in is accepted from edge T+131 onward.
- dout holds its value between results.
- LUT writes during RUN take effect immediately, so the in-flight result may mix old and new entries. Loading is only supported while idle.
- Delay-line wrap: the oldest sample is discarded on every accepted strobe.

Test Plan:
- LUT all zero, 5 random samples → 5 valid_out pulses, each 130 cycles after its valid_in, each with dout=0.
- h0=16384 only (entries with a[0]=1 in group 0 hold 16384, all others 0), din=1000 → dout=500. Next sample din=-1000 → dout=-500.
- h5=32767 only, inputs 1000 then zeros → dout sequence 0,0,0,0,0,999,0 (tap-5 delay; floor rounding).
- h0=-32768, din=-32768 → raw 32768, so dout=32767 (saturation). h0=32767, din=-32768 → dout=-32767.
- Second valid_in 50 cycles after the first → ignored: exactly one valid_out, and the delay line shifted once.
- resetn=1 at cycle 60 of RUN → no valid_out, dout=0. A following sample (h0=16384, din=1000) gives dout=500 with all history zero. LUT contents are preserved through reset.
